uart_tx_fifo: RTL and testbench

- Parametrised successor to the single-byte UART transmitter.
- Adds a compile-time data width, a runtime baud divisor and an internal transmit FIFO, so software can queue several words back-to-back.
- Sits between the UART register interface (push side) and the txd pad.
- Frame: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, 1 or 2 stop bits.

---
 rtl/uart_phy_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_tx_fifo.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_phy_pkg.sv
// Shared UART transmit definitions: FSM state type and parity encodings.
package uart_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } tx_state_t;

  // parity_type encodings: bit 1 enables parity, bit 0 selects odd
  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b10;
  localparam logic [1:0] PARITY_ODD  = 2'b11;

  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype & PARITY_EVEN) != PARITY_NONE;
  endfunction

  function automatic logic parity_is_odd(input logic [1:0] ptype);
    return ptype == PARITY_ODD;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head-of-queue read and occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal FIFO; frame config is shadowed per frame.
module uart_tx_fifo
  import uart_phy_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          tx_en,
  input  logic [1:0]                    parity_type,
  input  logic                          nstop,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          txd,
  output logic                          tx_busy,
  output logic                          tx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  tx_state_t             state, state_n;
  logic [DIV_WIDTH-1:0]  bit_cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic [DATA_WIDTH-1:0] shift_reg, shift_n;
  logic [1:0]            sh_par, sh_par_n;
  logic                  sh_nstop, sh_nstop_n;
  logic [DIV_WIDTH-1:0]  sh_div, sh_div_n;
  logic                  txd_r, txd_n;

  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  bit_done;
  logic                  can_start;
  logic                  load_frame;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (data_valid),
    .pop   (fifo_pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign data_ready = !fifo_full;
  assign tx_busy    = (state != ST_IDLE);
  assign tx_empty   = fifo_empty && (state == ST_IDLE);
  assign txd        = txd_r;
  assign bit_done   = (bit_cnt == '0);
  assign can_start  = tx_en && !fifo_empty;

  // State, timing and shadow registers; txd is registered from the next-state view.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      idx       <= '0;
      shift_reg <= '0;
      sh_par    <= PARITY_NONE;
      sh_nstop  <= 1'b0;
      sh_div    <= '0;
      txd_r     <= 1'b1;
    end else begin
      state     <= state_n;
      bit_cnt   <= cnt_n;
      idx       <= idx_n;
      shift_reg <= shift_n;
      sh_par    <= sh_par_n;
      sh_nstop  <= sh_nstop_n;
      sh_div    <= sh_div_n;
      txd_r     <= txd_n;
    end
  end

  // Next-state, bit timing, FIFO pop and next line level.
  always_comb begin
    state_n    = state;
    cnt_n      = bit_cnt;
    idx_n      = idx;
    shift_n    = shift_reg;
    sh_par_n   = sh_par;
    sh_nstop_n = sh_nstop;
    sh_div_n   = sh_div;
    fifo_pop   = 1'b0;
    load_frame = 1'b0;
    txd_n      = 1'b1;

    if (state != ST_IDLE && !bit_done) begin
      cnt_n = bit_cnt - DIV_WIDTH'(1);
    end

    unique case (state)
      ST_IDLE: begin
        load_frame = can_start;
      end
      ST_START: begin
        if (bit_done) begin
          state_n = ST_DATA;
          idx_n   = '0;
          cnt_n   = sh_div;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_n = sh_div;
          if (idx == LAST_IDX) begin
            state_n = parity_enabled(sh_par) ? ST_PARITY : ST_STOP1;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_n = ST_STOP1;
          cnt_n   = sh_div;
        end
      end
      ST_STOP1: begin
        if (bit_done) begin
          if (sh_nstop) begin
            state_n = ST_STOP2;
            cnt_n   = sh_div;
          end else if (can_start) begin
            load_frame = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_STOP2: begin
        if (bit_done) begin
          if (can_start) begin
            load_frame = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (load_frame) begin
      fifo_pop   = 1'b1;
      shift_n    = fifo_dout;
      sh_par_n   = parity_type;
      sh_nstop_n = nstop;
      sh_div_n   = baud_div;
      cnt_n      = baud_div;
      state_n    = ST_START;
    end

    // Level for the bit being entered, so txd changes on the same edge as state.
    unique case (state_n)
      ST_START:  txd_n = 1'b0;
      ST_DATA:   txd_n = shift_n[idx_n];
      ST_PARITY: txd_n = (^shift_n) ^ parity_is_odd(sh_par_n);
      default:   txd_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench: stimulus queues expected frames, a line monitor decodes txd.
module tb_uart_tx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DIVW  = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            tx_en = 1'b0;
  logic [1:0]      parity_type = 2'b00;
  logic            nstop = 1'b0;
  logic [DIVW-1:0] baud_div = '0;
  logic [DW-1:0]   data_in = '0;
  logic            data_valid = 1'b0;
  logic            data_ready;
  logic            txd;
  logic            tx_busy;
  logic            tx_empty;
  logic [3:0]      fifo_count;

  typedef struct {
    logic [7:0]  data;
    int unsigned div;
    logic [1:0]  par;
    logic        nstop;
  } frame_t;

  frame_t      exp_q[$];
  int unsigned gaps[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned frames_started = 0;
  int unsigned frames_aborted = 0;
  logic        in_frame = 1'b0;
  logic        track = 1'b0;
  int unsigned peak = 0;

  uart_tx_fifo #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .DIV_WIDTH  (DIVW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tx_en       (tx_en),
    .parity_type (parity_type),
    .nstop       (nstop),
    .baud_div    (baud_div),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .txd         (txd),
    .tx_busy     (tx_busy),
    .tx_empty    (tx_empty),
    .fifo_count  (fifo_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (track && int'(fifo_count) > peak) peak = int'(fifo_count);
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic set_cfg(input int unsigned div, input logic [1:0] par, input logic ns);
    baud_div    = DIVW'(div);
    parity_type = par;
    nstop       = ns;
  endtask

  // Called at posedge+1; leaves the bus idle at the next posedge+1.
  task automatic push_word(input logic [7:0] d, input bit chk, input bit exp_ready);
    data_in    = d;
    data_valid = 1'b1;
    @(negedge clock);
    if (chk) check("data_ready", int'(data_ready), int'(exp_ready));
    @(posedge clock);
    #1 data_valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] d);
    frame_t f;
    f.data  = d;
    f.div   = int'(baud_div);
    f.par   = parity_type;
    f.nstop = nstop;
    exp_q.push_back(f);
  endtask

  task automatic drain(input int unsigned maxc);
    bit done;
    done = 0;
    for (int unsigned n = 0; n < maxc && !done; n++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !in_frame && tx_empty) done = 1;
    end
    check("drain_done", int'(done), 1);
    check("idle_txd", int'(txd), 1);
  endtask

  // Line monitor: decodes each frame from txd and compares against the queue head.
  initial begin
    int unsigned gap;
    frame_t      e;
    logic        bits[$];
    int unsigned ones;
    int unsigned bad;
    bit          aborted;
    logic [7:0]  rx;
    gap = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        gap = 0;
      end else if (txd === 1'b1) begin
        gap++;
      end else begin
        in_frame = 1'b1;
        frames_started++;
        gaps.push_back(gap);
        gap = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=start expected=idle");
          while (!reset && txd !== 1'b1) @(negedge clock);
        end else begin
          e = exp_q.pop_front();
          bits.delete();
          bits.push_back(1'b0);
          ones = 0;
          for (int unsigned i = 0; i < 8; i++) begin
            bits.push_back(e.data[i]);
            if (e.data[i]) ones++;
          end
          if (e.par[1]) bits.push_back(((ones % 2) == 1) ^ e.par[0]);
          bits.push_back(1'b1);
          if (e.nstop) bits.push_back(1'b1);
          bad = 0;
          aborted = 0;
          rx = '0;
          for (int b = 0; b < bits.size() && !aborted; b++) begin
            for (int unsigned c = 0; c <= e.div && !aborted; c++) begin
              if (!(b == 0 && c == 0)) begin
                @(negedge clock);
                if (reset) aborted = 1;
              end
              if (!aborted) begin
                if (txd !== bits[b]) bad++;
                if (c == 0 && b >= 1 && b <= 8) rx[b-1] = txd;
              end
            end
          end
          if (aborted) begin
            frames_aborted++;
          end else begin
            checks++;
            if (bad != 0) begin
              errors++;
              $display("FAIL frame actual=%h expected=%h bad_samples=%0d div=%0d par=%b nstop=%0d",
                       rx, e.data, bad, e.div, e.par, e.nstop);
            end
          end
        end
        in_frame = 1'b0;
      end
    end
  end

  initial begin
    int unsigned base;
    int unsigned tb_occ;
    int unsigned started;
    logic [7:0]  w;

    // 1: reset and idle
    set_cfg(0, 2'b00, 1'b0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_txd", int'(txd), 1);
    check("rst_ready", int'(data_ready), 1);
    check("rst_empty", int'(tx_empty), 1);
    check("rst_count", int'(fifo_count), 0);
    check("rst_busy", int'(tx_busy), 0);

    // 2: single word, even parity, 4 clocks per bit, first-bit latency
    @(posedge clock);
    #1;
    set_cfg(3, 2'b10, 1'b0);
    tx_en = 1'b1;
    expect_frame(8'hA5);
    push_word(8'hA5, 1, 1);
    @(negedge clock);
    check("lat_txd_n", int'(txd), 1);
    check("lat_count_n", int'(fifo_count), 1);
    @(negedge clock);
    check("lat_txd_n1", int'(txd), 0);
    check("lat_busy", int'(tx_busy), 1);
    drain(200);
    check("single_gap_after", int'(tx_empty), 1);

    // 3: burst of three, odd parity, two stops, back-to-back
    @(posedge clock);
    #1;
    set_cfg(0, 2'b11, 1'b1);
    base = gaps.size();
    peak = 0;
    track = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w = 8'($urandom);
      expect_frame(w);
      push_word(w, 1, 1);
    end
    drain(200);
    track = 1'b0;
    check("burst_peak_ok", int'(peak == 2 || peak == 3), 1);
    check("burst_frames", int'(gaps.size() - base), 3);
    if (gaps.size() >= base + 3) begin
      check("burst_gap1", int'(gaps[base+1]), 0);
      check("burst_gap2", int'(gaps[base+2]), 0);
    end

    // 4: fill the FIFO with tx disabled; overflow words are dropped
    @(posedge clock);
    #1;
    tx_en = 1'b0;
    set_cfg($urandom_range(0, 2), 2'b10 | 2'($urandom_range(0, 1)), 1'($urandom));
    tb_occ = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      w = 8'($urandom);
      if (tb_occ < DEPTH) begin
        expect_frame(w);
        push_word(w, 1, 1);
        tb_occ++;
      end else begin
        push_word(w, 1, 0);
      end
    end
    @(negedge clock);
    check("full_count", int'(fifo_count), DEPTH);
    check("full_ready", int'(data_ready), 0);
    check("full_no_start", int'(tx_busy), 0);
    @(posedge clock);
    #1 tx_en = 1'b1;
    drain(2000);

    // 5: config change mid-frame only affects the following frame
    @(posedge clock);
    #1;
    set_cfg(1, 2'b00, 1'b0);
    expect_frame(8'h3C);
    push_word(8'h3C, 0, 1);
    repeat (4) @(posedge clock);
    #1;
    set_cfg(5, 2'b11, 1'b1);
    w = 8'($urandom);
    expect_frame(w);
    push_word(w, 0, 1);
    drain(500);

    // 6: asynchronous reset in the middle of the data bits
    @(posedge clock);
    #1;
    set_cfg(3, 2'b00, 1'b0);
    expect_frame(8'h00);
    push_word(8'h00, 0, 1);
    w = 8'($urandom);
    expect_frame(w);
    push_word(w, 0, 1);
    w = 8'($urandom);
    expect_frame(w);
    push_word(w, 0, 1);
    repeat (5) @(posedge clock);
    #2;
    check("pre_rst_txd", int'(txd), 0);
    #1 reset = 1'b1;
    #1;
    check("async_txd", int'(txd), 1);
    check("async_count", int'(fifo_count), 0);
    check("async_busy", int'(tx_busy), 0);
    check("async_ready", int'(data_ready), 1);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    started = frames_started;
    repeat (60) @(negedge clock);
    check("post_rst_frames", int'(frames_started - started), 0);
    check("post_rst_empty", int'(tx_empty), 1);
    check("aborted_frames", int'(frames_aborted), 1);

    // Randomised rounds: per-round config, irregular push spacing
    for (int r = 0; r < 6; r++) begin
      @(posedge clock);
      #1;
      set_cfg($urandom_range(0, 3), 2'($urandom), 1'($urandom));
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
        w = 8'($urandom);
        expect_frame(w);
        push_word(w, 0, 1);
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1;
      end
      drain(3000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
